logic_op_arbiter: RTL

- Shares one WIDTH-bit bitwise AND/OR unit between two requesters using valid/ready handshakes.
- Round-robin arbitration; one operation in flight; registered result with its own valid/ready response channel.
- Sits between two client blocks and the AND_gate/OR_gate datapath. The gates are instantiated inside this block, so no external datapath ports exist.

---
 rtl/logic_op_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter
//   Shares one WIDTH-bit bitwise AND/OR unit between two requesters. Requests
//   arrive on valid/ready channels and are arbitrated round-robin. Only one
//   operation is in flight. Its result is held on a valid/ready response
//   channel until the consumer accepts it.
//
// Ports
//   clk, rst              system clock; synchronous active-high reset
//   req{0,1}_valid/ready  request handshake per requester
//   req{0,1}_a/_b         operands
//   req{0,1}_op           opcode: 0 = AND, 1 = OR
//   rsp_valid/ready       response handshake
//   rsp_data              result of the granted request
//   rsp_id                requester index that owns rsp_data
//   done_cnt              completed responses, wraps modulo 2^CNT_W

// and_gate: WIDTH-bit bitwise AND.
module and_gate #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a & b;
endmodule

// or_gate: WIDTH-bit bitwise OR.
module or_gate #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a | b;
endmodule

module logic_op_arbiter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [0:0] {StIdle, StResp} state_t;

    state_t           state_q, state_d;
    logic             prio_q;
    logic             id_q;
    logic             op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CNT_W-1:0] done_cnt_q;

    logic             grant_valid;
    logic             grant_id;
    logic             accept;
    logic             rsp_done;
    logic [WIDTH-1:0] and_y, or_y;

    // Grant: a lone requester wins; on contention the favoured one (prio_q) wins.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = prio_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    // Next state and request readies.
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                req0_ready = grant_valid && (grant_id == 1'b0);
                req1_ready = grant_valid && (grant_id == 1'b1);
                if (grant_valid) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign rsp_done = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            prio_q     <= 1'b0;
            id_q       <= 1'b0;
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            // Operands are captured so later requester changes cannot disturb the result.
            if (accept) begin
                id_q <= grant_id;
                op_q <= grant_id ? req1_op : req0_op;
                a_q  <= grant_id ? req1_a  : req0_a;
                b_q  <= grant_id ? req1_b  : req0_b;
            end
            if (rsp_done) begin
                done_cnt_q <= done_cnt_q + CNT_W'(1);
                prio_q     <= ~id_q;
            end
        end
    end

    and_gate #(
        .WIDTH (WIDTH)
    ) u_and_gate (
        .a (a_q),
        .b (b_q),
        .y (and_y)
    );

    or_gate #(
        .WIDTH (WIDTH)
    ) u_or_gate (
        .a (a_q),
        .b (b_q),
        .y (or_y)
    );

    // Result is a pure function of registered operands, so it is stable in StResp.
    assign rsp_data  = op_q ? or_y : and_y;
    assign rsp_valid = (state_q == StResp);
    assign rsp_id    = id_q;
    assign done_cnt  = done_cnt_q;

endmodule
